sequenciador_pilha: RTL and testbench

Control unit for the 16-bit data stack. It arbitrates stack access between the control unit (UC) and the ALU (ULA), and sequences multi-cycle stack operations. It drives the stack's push, pop and source-select (`controle_pilha`) lines, and checks overflow and underflow against the stack's top-of-stack index. It sits between the UC, the ULA and the stack, and is the only block that drives the stack's control inputs.

---
 rtl/sequenciador_pilha.sv | 146 ++++++++++++++
 tb/tb_sequenciador_pilha.sv | 365 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sequenciador_pilha.sv
// Stack sequencer: arbitrates UC/ULA access to the 16-bit data stack and sequences
// push, pop and two-operand ALU operations with overflow/underflow/timeout checks.
module sequenciador_pilha #(
    parameter int unsigned PROF    = 16,
    parameter int unsigned TIMEOUT = 64
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        uc_push_req,
    input  logic        uc_pop_req,
    input  logic        uc_op_req,
    output logic        uc_ack,
    output logic        uc_erro,
    output logic [15:0] uc_dado,
    output logic        pilha_push,
    output logic        pilha_pop,
    output logic        controle_pilha,
    input  logic [15:0] pilha_dout,
    input  logic [15:0] pilha_tos,
    output logic [15:0] ula_a,
    output logic [15:0] ula_b,
    output logic        ula_start,
    input  logic        ula_done,
    output logic        ocupado,
    output logic        erro_under,
    output logic        erro_over,
    output logic        erro_ula
);

    localparam logic [3:0] OCIOSO     = 4'd0;
    localparam logic [3:0] PUSH_UC    = 4'd1;
    localparam logic [3:0] POP_UC     = 4'd2;
    localparam logic [3:0] CAP_UC     = 4'd3;
    localparam logic [3:0] POP_B      = 4'd4;
    localparam logic [3:0] CAP_B      = 4'd5;
    localparam logic [3:0] POP_A      = 4'd6;
    localparam logic [3:0] CAP_A      = 4'd7;
    localparam logic [3:0] EXEC       = 4'd8;
    localparam logic [3:0] ESPERA_ULA = 4'd9;
    localparam logic [3:0] PUSH_R     = 4'd10;

    localparam logic [7:0]  CNT_ULTIMO = 8'(TIMEOUT - 1);
    localparam logic [15:0] TOS_CHEIO  = 16'(PROF);

    logic [3:0] state_q, state_d;
    logic [7:0] cnt_q, cnt_d;
    logic       erro_q, erro_d;
    logic       set_under, set_over, set_ula;

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        erro_d    = 1'b0;
        set_under = 1'b0;
        set_over  = 1'b0;
        set_ula   = 1'b0;
        case (state_q)
            OCIOSO: begin
                // Rejects stay in OCIOSO; the ack/erro pulse comes from erro_q next cycle.
                if (uc_op_req) begin
                    if (pilha_tos < 16'd2) begin
                        erro_d    = 1'b1;
                        set_under = 1'b1;
                    end else begin
                        state_d = POP_B;
                    end
                end else if (uc_pop_req) begin
                    if (pilha_tos == 16'd0) begin
                        erro_d    = 1'b1;
                        set_under = 1'b1;
                    end else begin
                        state_d = POP_UC;
                    end
                end else if (uc_push_req) begin
                    if (pilha_tos >= TOS_CHEIO) begin
                        erro_d   = 1'b1;
                        set_over = 1'b1;
                    end else begin
                        state_d = PUSH_UC;
                    end
                end
            end
            PUSH_UC: state_d = OCIOSO;
            POP_UC:  state_d = CAP_UC;
            CAP_UC:  state_d = OCIOSO;
            POP_B:   state_d = CAP_B;
            CAP_B:   state_d = POP_A;
            POP_A:   state_d = CAP_A;
            CAP_A:   state_d = EXEC;
            EXEC: begin
                cnt_d   = 8'd0;
                state_d = ESPERA_ULA;
            end
            ESPERA_ULA: begin
                if (ula_done) begin
                    state_d = PUSH_R;
                end else if (cnt_q == CNT_ULTIMO) begin
                    // Operands already popped are dropped; nothing is pushed back.
                    state_d = OCIOSO;
                    erro_d  = 1'b1;
                    set_ula = 1'b1;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            PUSH_R:  state_d = OCIOSO;
            default: state_d = OCIOSO;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= OCIOSO;
            cnt_q      <= 8'd0;
            erro_q     <= 1'b0;
            erro_under <= 1'b0;
            erro_over  <= 1'b0;
            erro_ula   <= 1'b0;
            uc_dado    <= 16'd0;
            ula_a      <= 16'd0;
            ula_b      <= 16'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            erro_q  <= erro_d;
            if (set_under) erro_under <= 1'b1;
            if (set_over)  erro_over  <= 1'b1;
            if (set_ula)   erro_ula   <= 1'b1;
            if (state_q == CAP_UC) uc_dado <= pilha_dout;
            if (state_q == CAP_B)  ula_b   <= pilha_dout;
            if (state_q == CAP_A)  ula_a   <= pilha_dout;
        end
    end

    always_comb begin
        pilha_push     = (state_q == PUSH_UC) || (state_q == PUSH_R);
        pilha_pop      = (state_q == POP_UC) || (state_q == POP_B) || (state_q == POP_A);
        controle_pilha = (state_q == PUSH_R);
        ula_start      = (state_q == EXEC);
        ocupado        = (state_q != OCIOSO);
        uc_ack         = (state_q == PUSH_UC) || (state_q == CAP_UC) || (state_q == PUSH_R)
                         || erro_q;
        uc_erro        = erro_q;
    end

endmodule

// File: tb/tb_sequenciador_pilha.sv
// Bench for sequenciador_pilha: stack and ALU environment models, a queue-based reference
// of the stack contents, and a scoreboard monitor that checks every ack.
module tb_sequenciador_pilha;

    localparam int unsigned PROF    = 16;
    localparam int unsigned TIMEOUT = 64;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        uc_push_req = 1'b0, uc_pop_req = 1'b0, uc_op_req = 1'b0;
    logic        uc_ack, uc_erro;
    logic [15:0] uc_dado;
    logic        pilha_push, pilha_pop, controle_pilha;
    logic [15:0] st_dout, st_tos;
    logic [15:0] ula_a, ula_b;
    logic        ula_start;
    logic        ula_done = 1'b0;
    logic        ocupado, erro_under, erro_over, erro_ula;

    logic [15:0] din_uc  = 16'd0;
    logic [15:0] ula_res = 16'd0;
    logic        ula_mute = 1'b0;
    int          ula_dly  = 0;
    int          cyc      = 0;
    int          done_cyc = -100;

    int n_pass  = 0;
    int n_total = 0;

    typedef struct packed {
        logic [1:0]  kind;   // 0 push, 1 pop, 2 op
        logic        erro;
        logic        tout;
        logic [15:0] dado;
    } exp_t;

    typedef struct packed {
        logic [15:0] a;
        logic [15:0] b;
    } op_t;

    exp_t        exp_q[$];
    op_t         op_q[$];
    logic [15:0] ref_q[$];
    logic        m_under = 1'b0, m_over = 1'b0, m_ula = 1'b0;

    sequenciador_pilha #(.PROF(PROF), .TIMEOUT(TIMEOUT)) dut (
        .clk            (clk),
        .rst            (rst),
        .uc_push_req    (uc_push_req),
        .uc_pop_req     (uc_pop_req),
        .uc_op_req      (uc_op_req),
        .uc_ack         (uc_ack),
        .uc_erro        (uc_erro),
        .uc_dado        (uc_dado),
        .pilha_push     (pilha_push),
        .pilha_pop      (pilha_pop),
        .controle_pilha (controle_pilha),
        .pilha_dout     (st_dout),
        .pilha_tos      (st_tos),
        .ula_a          (ula_a),
        .ula_b          (ula_b),
        .ula_start      (ula_start),
        .ula_done       (ula_done),
        .ocupado        (ocupado),
        .erro_under     (erro_under),
        .erro_over      (erro_over),
        .erro_ula       (erro_ula)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Stack environment: registered read, shares rst with the sequencer.
    logic [15:0] mem [PROF];
    always @(posedge clk) begin
        if (rst) begin
            st_tos  <= 16'd0;
            st_dout <= 16'd0;
        end else if (pilha_push) begin
            if (int'(st_tos) < PROF) begin
                mem[int'(st_tos)] <= controle_pilha ? ula_res : din_uc;
                st_tos            <= st_tos + 16'd1;
            end
        end else if (pilha_pop) begin
            if (st_tos != 16'd0) begin
                st_dout <= mem[int'(st_tos) - 1];
                st_tos  <= st_tos - 16'd1;
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
        n_total++;
        if (act === expv) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, expv);
    endtask

    function automatic exp_t mk(input logic [1:0] kind, input logic erro, input logic tout,
                                input logic [15:0] dado);
        exp_t e;
        e.kind = kind;
        e.erro = erro;
        e.tout = tout;
        e.dado = dado;
        return e;
    endfunction

    // ALU environment: result = a - b, done ula_dly+1 cycles after the start cycle.
    initial begin
        forever begin
            @(negedge clk);
            if (!rst && ula_start && !ula_mute) begin
                @(negedge clk);
                repeat (ula_dly) @(negedge clk);
                if (!rst) begin
                    ula_res  = ula_a - ula_b;
                    ula_done = 1'b1;
                    done_cyc = cyc;
                    @(negedge clk);
                    ula_done = 1'b0;
                end
            end
        end
    end

    // Scoreboard monitor.
    initial begin
        exp_t        e;
        op_t         o;
        logic        dado_pend;
        logic [15:0] dado_exp;
        int          start_cyc;
        dado_pend = 1'b0;
        dado_exp  = 16'd0;
        start_cyc = -1000;
        forever begin
            @(negedge clk);
            if (rst) begin
                dado_pend = 1'b0;
            end else begin
                if (dado_pend) begin
                    chk("uc_dado_after_pop", 32'(uc_dado), 32'(dado_exp));
                    dado_pend = 1'b0;
                end
                if (ula_start) begin
                    start_cyc = cyc;
                    if (op_q.size() == 0) begin
                        chk("unexpected_ula_start", 32'(1), 32'(0));
                    end else begin
                        o = op_q.pop_front();
                        chk("ula_a", 32'(ula_a), 32'(o.a));
                        chk("ula_b", 32'(ula_b), 32'(o.b));
                    end
                end
                if (pilha_push) chk("push_excl_and_room", 32'({pilha_pop, int'(st_tos) < PROF}),
                                    32'(2'b01));
                if (uc_ack) begin
                    if (exp_q.size() == 0) begin
                        chk("unexpected_ack", 32'(1), 32'(0));
                    end else begin
                        e = exp_q.pop_front();
                        chk("uc_erro", 32'(uc_erro), 32'(e.erro));
                        if (e.erro) begin
                            chk("no_strobe_on_reject", 32'({pilha_push, pilha_pop}), 32'(0));
                        end else if (e.kind == 2'd0) begin
                            chk("push_uc_strobe", 32'({pilha_push, controle_pilha}), 32'(2'b10));
                        end else if (e.kind == 2'd2) begin
                            chk("push_r_strobe", 32'({pilha_push, controle_pilha}), 32'(2'b11));
                            chk("done_to_ack", 32'(cyc), 32'(done_cyc + 1));
                        end else begin
                            dado_pend = 1'b1;
                            dado_exp  = e.dado;
                        end
                        if (e.tout) chk("timeout_cycle", 32'(cyc), 32'(start_cyc + 1 + TIMEOUT));
                    end
                end else if (uc_erro) begin
                    chk("erro_without_ack", 32'(1), 32'(0));
                end
            end
        end
    end

    // Issue one request set; the reference predicts results in op/pop/push service order.
    task automatic do_txn(input bit p, input bit pp, input bit o, input logic [15:0] d,
                          input bit mute, input int dly);
        int          outs[$];
        int          k;
        int          budget;
        logic [15:0] a, b, v;
        op_t         op;
        ula_mute = mute;
        ula_dly  = dly;
        din_uc   = d;
        if (o) begin
            outs.push_back(2);
            if (ref_q.size() < 2) begin
                exp_q.push_back(mk(2'd2, 1'b1, 1'b0, 16'd0));
                m_under = 1'b1;
            end else begin
                b = ref_q.pop_back();
                a = ref_q.pop_back();
                op.a = a;
                op.b = b;
                op_q.push_back(op);
                if (mute) begin
                    exp_q.push_back(mk(2'd2, 1'b1, 1'b1, 16'd0));
                    m_ula = 1'b1;
                end else begin
                    ref_q.push_back(a - b);
                    exp_q.push_back(mk(2'd2, 1'b0, 1'b0, 16'd0));
                end
            end
        end
        if (pp) begin
            outs.push_back(1);
            if (ref_q.size() == 0) begin
                exp_q.push_back(mk(2'd1, 1'b1, 1'b0, 16'd0));
                m_under = 1'b1;
            end else begin
                v = ref_q.pop_back();
                exp_q.push_back(mk(2'd1, 1'b0, 1'b0, v));
            end
        end
        if (p) begin
            outs.push_back(0);
            if (ref_q.size() >= PROF) begin
                exp_q.push_back(mk(2'd0, 1'b1, 1'b0, 16'd0));
                m_over = 1'b1;
            end else begin
                ref_q.push_back(d);
                exp_q.push_back(mk(2'd0, 1'b0, 1'b0, 16'd0));
            end
        end
        @(negedge clk);
        uc_op_req   = o;
        uc_pop_req  = pp;
        uc_push_req = p;
        budget = 200 + 2 * TIMEOUT;
        while (outs.size() > 0 && budget > 0) begin
            @(negedge clk);
            budget--;
            if (uc_ack) begin
                k = outs.pop_front();
                if (k == 2) uc_op_req = 1'b0;
                else if (k == 1) uc_pop_req = 1'b0;
                else uc_push_req = 1'b0;
            end
        end
        if (outs.size() > 0) begin
            chk("ack_wait_expired", 32'(outs.size()), 32'(0));
            uc_op_req   = 1'b0;
            uc_pop_req  = 1'b0;
            uc_push_req = 1'b0;
        end
        @(negedge clk);
        chk("pilha_tos", 32'(st_tos), 32'(ref_q.size()));
        chk("ocupado_idle", 32'(ocupado), 32'(0));
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        op_t op;
        int  r;
        int  budget;

        // Reset
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("reset_outputs", 32'({uc_ack, uc_erro, pilha_push, pilha_pop, controle_pilha,
                                  ula_start, ocupado, erro_under, erro_over, erro_ula}), 32'(0));
        chk("reset_uc_dado", 32'(uc_dado), 32'(0));
        chk("reset_ula_ab", {ula_a, ula_b}, 32'(0));
        rst = 1'b0;

        // Push/pop
        do_txn(1, 0, 0, 16'h1234, 0, 0);
        do_txn(1, 0, 0, 16'hABCD, 0, 0);
        do_txn(0, 1, 0, 16'h0000, 0, 0);
        do_txn(0, 1, 0, 16'h0000, 0, 0);

        // Pop on empty stack
        do_txn(0, 1, 0, 16'h0000, 0, 0);
        chk("erro_under_set", 32'(erro_under), 32'(1));

        // ALU op on [5, 3], done two cycles after start
        do_txn(1, 0, 0, 16'd5, 0, 0);
        do_txn(1, 0, 0, 16'd3, 0, 0);
        do_txn(0, 0, 1, 16'd0, 0, 1);

        // Op with a single entry is rejected
        do_txn(0, 0, 1, 16'd0, 0, 0);
        do_txn(0, 1, 0, 16'd0, 0, 0);

        // Fill, then overflow
        for (int i = 0; i < PROF; i++) do_txn(1, 0, 0, 16'($urandom), 0, 0);
        chk("erro_over_clear", 32'(erro_over), 32'(0));
        do_txn(1, 0, 0, 16'hDEAD, 0, 0);
        chk("erro_over_set", 32'(erro_over), 32'(1));

        // All three requests together
        do_txn(1, 1, 1, 16'h0F0F, 0, 2);

        // ALU timeout
        do_txn(0, 0, 1, 16'd0, 1, 0);
        chk("erro_ula_set", 32'(erro_ula), 32'(1));
        chk("flags_model", 32'({erro_under, erro_over, erro_ula}), 32'({m_under, m_over, m_ula}));

        // Reset during ESPERA_ULA
        ula_mute = 1'b1;
        op.a = ref_q[ref_q.size() - 2];
        op.b = ref_q[ref_q.size() - 1];
        op_q.push_back(op);
        @(negedge clk);
        uc_op_req = 1'b1;
        budget = 50;
        while (!ula_start && budget > 0) begin
            @(negedge clk);
            budget--;
            if (ocupado) uc_op_req = 1'b0;
        end
        chk("ula_start_seen", 32'(ula_start), 32'(1));
        uc_op_req = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk("rst_abort_idle", 32'({ocupado, uc_ack, pilha_push}), 32'(0));
        ref_q.delete();
        exp_q.delete();
        op_q.delete();
        m_under = 1'b0;
        m_over  = 1'b0;
        m_ula   = 1'b0;
        rst = 1'b0;
        repeat (4) @(negedge clk);
        chk("rst_abort_tos", 32'(st_tos), 32'(0));
        chk("rst_abort_flags", 32'({erro_under, erro_over, erro_ula}), 32'(0));

        // Randomized traffic
        for (int i = 0; i < 150; i++) begin
            r = int'($urandom_range(0, 99));
            if (r < 45)      do_txn(1, 0, 0, 16'($urandom), 0, 0);
            else if (r < 75) do_txn(0, 1, 0, 16'd0, 0, 0);
            else if (r < 92) do_txn(0, 0, 1, 16'd0, 0, int'($urandom_range(0, 4)));
            else             do_txn(1, 1, 1, 16'($urandom), 0, int'($urandom_range(0, 4)));
            repeat ($urandom_range(0, 2)) @(negedge clk);
        end
        chk("flags_final", 32'({erro_under, erro_over, erro_ula}), 32'({m_under, m_over, m_ula}));

        // Drain and verify remaining contents
        for (int i = 0; i < PROF && ref_q.size() > 0; i++) do_txn(0, 1, 0, 16'd0, 0, 0);
        repeat (3) @(negedge clk);
        chk("scoreboard_empty", 32'(exp_q.size() + op_q.size()), 32'(0));

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
